// File: rtl/frame_cfg_pkg.sv
// Shared constants for the configuration-frame sequencer: header layout,
// magic value, state encoding and the header acceptance rule.
package frame_cfg_pkg;

  localparam logic [3:0] FRAME_MAGIC = 4'hA;

  localparam int HDR_MAGIC_MSB = 31;
  localparam int HDR_MAGIC_LSB = 28;
  localparam int HDR_COL_MSB   = 27;
  localparam int HDR_COL_LSB   = 20;
  localparam int HDR_FRAME_MSB = 19;
  localparam int HDR_FRAME_LSB = 12;
  localparam int HDR_ROWS_MSB  = 11;
  localparam int HDR_ROWS_LSB  = 0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    STROBE = ST_STROBE,
    HOLD   = ST_HOLD
  } state_t;

  // A header is taken only if every field is usable; anything else is dropped whole.
  function automatic logic hdr_valid(input logic [31:0] word, input int cols,
                                     input int frames, input int rows);
    return (word[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == FRAME_MAGIC) &&
           (int'(word[HDR_COL_MSB:HDR_COL_LSB]) < cols) &&
           (int'(word[HDR_FRAME_MSB:HDR_FRAME_LSB]) < frames) &&
           (int'(word[HDR_ROWS_MSB:HDR_ROWS_LSB]) == rows);
  endfunction

endpackage

// File: rtl/frame_strobe_decode.sv
// Registered (column, frame) -> one-hot FrameStrobe decoder. The output is
// all-zero whenever enable is low, so it is zero or one-hot by construction.
module frame_strobe_decode #(
  parameter int NumColumns      = 4,
  parameter int MaxFramesPerCol = 20,
  parameter int ColW            = 2,
  parameter int FrameW          = 5
) (
  input  logic                                  UserCLK,
  input  logic                                  reset,
  input  logic [ColW-1:0]                       column,
  input  logic [FrameW-1:0]                     frame,
  input  logic                                  enable,
  output logic [MaxFramesPerCol*NumColumns-1:0] frame_strobe
);

  logic [MaxFramesPerCol*NumColumns-1:0] strobe_nxt;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    strobe_nxt = '0;
    for (int c = 0; c < NumColumns; c++) begin
      for (int f = 0; f < MaxFramesPerCol; f++) begin
        if (enable && column == ColW'(c) && frame == FrameW'(f)) begin
          strobe_nxt[c*MaxFramesPerCol+f] = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge UserCLK) begin
    if (reset) frame_strobe <= '0;
    else       frame_strobe <= strobe_nxt;
  end

endmodule

// File: rtl/frame_config_ctrl.sv
// Configuration-frame sequencer: takes header + one word per row, commits the
// column's FrameData and then strobes exactly one (column, frame) bit.
module frame_config_ctrl
  import frame_cfg_pkg::*;
#(
  parameter int NumColumns      = 4,
  parameter int NumRows         = 4,
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int STROBE_CYCLES   = 2
) (
  input  logic                                  UserCLK,
  input  logic                                  reset,
  input  logic [31:0]                           cfg_data,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  output logic [FrameBitsPerRow*NumRows-1:0]    FrameData,
  output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic [15:0]                           frame_count
);

  localparam int ColW   = (NumColumns > 1) ? $clog2(NumColumns) : 1;
  localparam int FrameW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int RowW   = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int StbW   = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);
  localparam logic [StbW-1:0] LastStb = StbW'(STROBE_CYCLES - 1);

  state_t state, state_nxt;

  logic [RowW-1:0]            row_idx;
  logic [StbW-1:0]            stb_cnt;
  logic [ColW-1:0]            col_q;
  logic [FrameW-1:0]          frame_q;
  logic [FrameBitsPerRow-1:0] shadow [NumRows];
  logic [FrameBitsPerRow*NumRows-1:0] commit_vec;

  logic accept, hdr_ok, last_row, last_stb;

  assign accept   = cfg_valid && cfg_ready;
  assign hdr_ok   = hdr_valid(cfg_data, NumColumns, MaxFramesPerCol, NumRows);
  assign last_row = (row_idx == LastRow);
  assign last_stb = (stb_cnt == LastStb);

  always_ff @(posedge UserCLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && hdr_ok)   state_nxt = LOAD;
      LOAD:    if (accept && last_row) state_nxt = STROBE;
      STROBE:  if (last_stb)           state_nxt = HOLD;
      HOLD:                            state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // The final row goes straight from cfg_data into the committed vector.
  always_comb begin
    commit_vec = '0;
    for (int r = 0; r < NumRows - 1; r++) begin
      commit_vec[r*FrameBitsPerRow +: FrameBitsPerRow] = shadow[r];
    end
    commit_vec[(NumRows-1)*FrameBitsPerRow +: FrameBitsPerRow] = cfg_data[FrameBitsPerRow-1:0];
  end

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      frame_count <= '0;
      FrameData   <= '0;
      row_idx     <= '0;
      stb_cnt     <= '0;
      col_q       <= '0;
      frame_q     <= '0;
    end else begin
      cfg_ready <= (state_nxt == IDLE) || (state_nxt == LOAD);
      busy      <= (state_nxt != IDLE);
      err       <= (state == IDLE) && accept && !hdr_ok;
      done      <= (state == STROBE) && last_stb;
      if (state == STROBE && last_stb) frame_count <= frame_count + 16'd1;

      if (state == IDLE && accept && hdr_ok) begin
        col_q   <= cfg_data[HDR_COL_LSB +: ColW];
        frame_q <= cfg_data[HDR_FRAME_LSB +: FrameW];
        row_idx <= '0;
      end

      if (state == LOAD && accept) begin
        row_idx <= last_row ? '0 : row_idx + RowW'(1);
        if (last_row) FrameData <= commit_vec;
      end

      if (state == STROBE) stb_cnt <= last_stb ? '0 : stb_cnt + StbW'(1);
      else                 stb_cnt <= '0;
    end
  end

  // NOTE: the shadow rows are not reset; a frame is only committed after every row has been rewritten.
  always_ff @(posedge UserCLK) begin
    if (state == LOAD && accept) shadow[row_idx] <= cfg_data[FrameBitsPerRow-1:0];
  end

  // The decoder output lags the state by one cycle: FrameData gets a setup cycle
  // before the strobe rises, and the strobe is gone before the next header lands.
  frame_strobe_decode #(
    .NumColumns      (NumColumns),
    .MaxFramesPerCol (MaxFramesPerCol),
    .ColW            (ColW),
    .FrameW          (FrameW)
  ) u_strobe (
    .UserCLK      (UserCLK),
    .reset        (reset),
    .column       (col_q),
    .frame        (frame_q),
    .enable       (state == STROBE),
    .frame_strobe (FrameStrobe)
  );

endmodule
